// File: rtl/fp_popcount_accum.sv
// fp_popcount_accum: accumulates popcount(A), popcount(B), popcount(A&B) over NWORDS-word fingerprint pairs.
// Define FPCNT_POPREG_EN to register the popcount trees ahead of the accumulators (latency 2 instead of 1).
module fp_popcount_accum #(
    parameter int DW     = 64,
    parameter int NWORDS = 16,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    input  logic [DW-1:0]    fa,
    input  logic [DW-1:0]    fb,
    input  logic             flush,
    output logic             vld_out,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);
    localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;

    if (NWORDS < 1 || WIDTH < $clog2(DW * NWORDS + 1)) begin : g_bad_params
        $error("fp_popcount_accum: NWORDS must be >= 1 and WIDTH >= clog2(DW*NWORDS+1)");
    end

    function automatic logic [WIDTH-1:0] pop(input logic [DW-1:0] x);
        pop = '0;
        for (int i = 0; i < DW; i++) pop = pop + WIDTH'(x[i]);
    endfunction

    logic             s_v;
    logic [WIDTH-1:0] pa, pb, pc;

`ifdef FPCNT_POPREG_EN
    logic             v_r;
    logic [WIDTH-1:0] pa_r, pb_r, pc_r;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v_r  <= 1'b0;
            pa_r <= '0;
            pb_r <= '0;
            pc_r <= '0;
        end else begin
            v_r  <= vld_in;
            pa_r <= pop(fa);
            pb_r <= pop(fb);
            pc_r <= pop(fa & fb);
        end

    // a flush also kills the word sitting in the popcount stage
    assign s_v = v_r & ~flush;
    assign pa  = pa_r;
    assign pb  = pb_r;
    assign pc  = pc_r;
`else
    assign s_v = vld_in;
    assign pa  = pop(fa);
    assign pb  = pop(fb);
    assign pc  = pop(fa & fb);
`endif

    logic [CW-1:0]    wcnt, base_w;
    logic [WIDTH-1:0] acc_a, acc_b, acc_c;
    logic [WIDTH-1:0] base_a, base_b, base_c;
    logic [WIDTH-1:0] na, nb, nc;
    logic             last;

    // flush zeroes the old pair, so a word arriving with it starts a fresh pair
    assign base_w = flush ? '0 : wcnt;
    assign base_a = flush ? '0 : acc_a;
    assign base_b = flush ? '0 : acc_b;
    assign base_c = flush ? '0 : acc_c;
    assign na     = base_a + pa;
    assign nb     = base_b + pb;
    assign nc     = base_c + pc;
    assign last   = s_v && base_w == CW'(NWORDS - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wcnt    <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            acc_c   <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            vld_out <= 1'b0;
        end else begin
            vld_out <= last;
            wcnt    <= last ? '0 : s_v ? base_w + CW'(1) : base_w;
            acc_a   <= last ? '0 : s_v ? na : base_a;
            acc_b   <= last ? '0 : s_v ? nb : base_b;
            acc_c   <= last ? '0 : s_v ? nc : base_c;
            if (last) begin
                a <= na;
                b <= nb;
                c <= nc;
            end
        end
endmodule

// File: tb/tb_fp_popcount_accum.sv
// tb_fp_popcount_accum: directed scoreboard bench for fp_popcount_accum (DW=64, NWORDS=4, WIDTH=32).
module tb_fp_popcount_accum;
    localparam int DW = 64;
    localparam int NW = 4;
    localparam int W  = 32;
`ifdef FPCNT_POPREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] PA   = 64'h00000000FFFFFFFF;
    localparam logic [DW-1:0] PB   = 64'hFFFF0000FFFF0000;

    logic          clk = 1'b0, rst_n = 1'b0, vld_in = 1'b0, flush = 1'b0;
    logic [DW-1:0] fa = '0, fb = '0;
    logic [W-1:0]  a, b, c;
    logic          vld_out;

    typedef struct {
        logic [W-1:0] a, b, c;
        int           cyc;
    } res_t;

    res_t         q[$];
    res_t         e;
    int           checks = 0, failures = 0, cyc = 0;
    logic [W-1:0] ha = '0, hb = '0, hc = '0;

    fp_popcount_accum #(.DW(DW), .NWORDS(NW), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .fa(fa), .fb(fb),
        .flush(flush), .vld_out(vld_out), .a(a), .b(b), .c(c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on each result pulse, otherwise outputs must hold the last result
    always @(negedge clk) begin
        if (vld_out === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_vld_out actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("res_a", a, e.a);
                chk("res_b", b, e.b);
                chk("res_c", c, e.c);
                chk("res_cycle", W'(cyc), W'(e.cyc));
                ha = e.a;
                hb = e.b;
                hc = e.c;
            end
        end else begin
            chk("hold_a", a, ha);
            chk("hold_b", b, hb);
            chk("hold_c", c, hc);
        end
    end

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic f = 1'b0);
        vld_in = 1'b1;
        fa     = x;
        fb     = y;
        flush  = f;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic idle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush_only();
        flush = 1'b1;
        idle();
        flush = 1'b0;
    endtask

    task automatic expect_res(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] xc);
        q.push_back('{xa, xb, xc, cyc + LAT});
    endtask

    initial begin
        #1;
        chk("reset_a", a, 0);
        chk("reset_vld", W'(vld_out), 0);
        idle(2);
        rst_n = 1'b1;
        // all-ones pair
        repeat (3) send(ONES, ONES);
        expect_res(256, 256, 256);
        send(ONES, ONES);
        idle(4);
        // two pairs back to back, no carry-over
        repeat (3) send(ONES, ONES);
        expect_res(256, 256, 256);
        send(ONES, ONES);
        repeat (3) send(PA, PB);
        expect_res(128, 128, 64);
        send(PA, PB);
        idle(4);
        // A only, contiguous then with idle gaps
        repeat (3) send(ONES, '0);
        expect_res(256, 0, 0);
        send(ONES, '0);
        idle(4);
        repeat (3) begin
            send(ONES, '0);
            idle();
        end
        expect_res(256, 0, 0);
        send(ONES, '0);
        idle(4);
        // partial pair aborted by a standalone flush
        repeat (2) send(ONES, ONES);
        flush_only();
        repeat (3) send(PA, PB);
        expect_res(128, 128, 64);
        send(PA, PB);
        idle(4);
        // flush coinciding with the first word of the new pair
        send(ONES, ONES);
        send(PA, PB, 1'b1);
        repeat (2) send(PA, PB);
        expect_res(128, 128, 64);
        send(PA, PB);
        idle(4);
        // async reset mid-pair
        repeat (3) send(ONES, ONES);
        rst_n = 1'b0;
        ha = '0;
        hb = '0;
        hc = '0;
        #1;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_c", c, 0);
        chk("rst_vld", W'(vld_out), 0);
        idle(2);
        rst_n = 1'b1;
        repeat (3) send(ONES, ONES);
        expect_res(256, 256, 256);
        send(ONES, ONES);
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        idle(2);
        chk("pending_results", W'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
